// File: rtl/cordic_linear_multiplier.sv
// Linear-rotation CORDIC multiplier: product = Input_a * Input_b using shift-add micro-rotations.
// Optional clamp-on-overflow with an Ovf_mult flag when CORDIC_MULT_SATURATION_EN is defined.
module cordic_linear_multiplier #(
    parameter int INT_LENGTH        = 17,
    parameter int FRAC_LENGTH       = 12,
    parameter int NUM_OF_ITERATIONS = 12,
    parameter int SCALE             = 5,
    localparam int WORD_LENGTH      = INT_LENGTH + FRAC_LENGTH
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Enable_mult,
    input  logic signed [WORD_LENGTH-1:0] Input_a,
    input  logic signed [WORD_LENGTH-1:0] Input_b,
    output logic signed [WORD_LENGTH-1:0] product,
    output logic                          Valid_mult,
`ifdef CORDIC_MULT_SATURATION_EN
    output logic                          Busy_mult,
    output logic                          Ovf_mult
`else
    output logic                          Busy_mult
`endif
);

    localparam int YW = WORD_LENGTH + SCALE + 1;
    localparam int CW = $clog2(NUM_OF_ITERATIONS + 1);

    localparam logic signed [WORD_LENGTH-1:0] ONE_S =
        {{(WORD_LENGTH-1){1'b0}}, 1'b1} << FRAC_LENGTH;
    localparam logic signed [WORD_LENGTH-1:0] NEG_ONE_S = -ONE_S;
    localparam logic [CW-1:0] ITER_INC  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ITER_LAST = CW'(NUM_OF_ITERATIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        state_r;
    logic [CW-1:0]                 iter_r;
    logic signed [WORD_LENGTH-1:0] x_r;
    logic signed [YW-1:0]          y_r;
    logic signed [WORD_LENGTH-1:0] z_r;
    logic                          scale_flag_r;

    logic                          b_big_s;
    logic signed [WORD_LENGTH-1:0] z_init_s;
    logic signed [WORD_LENGTH-1:0] x_shift_s;
    logic signed [YW-1:0]          x_ext_s;
    logic signed [WORD_LENGTH-1:0] one_shift_s;
    logic signed [YW-1:0]          y_next_s;
    logic signed [WORD_LENGTH-1:0] z_next_s;
    logic signed [WORD_LENGTH-1:0] prod_next_s;
    logic                          ovf_next_s;

`ifdef CORDIC_MULT_SATURATION_EN
    localparam int SW = YW + SCALE;
    localparam logic signed [SW-1:0] MAX_S =
        SW'({1'b0, {(WORD_LENGTH-1){1'b1}}});
    localparam logic signed [SW-1:0] MIN_S = -MAX_S - {{(SW-1){1'b0}}, 1'b1};

    // Clamp a wide value into the signed word range; top bit reports clamping.
    function automatic logic [WORD_LENGTH:0] sat_fn(input logic signed [SW-1:0] v);
        logic [WORD_LENGTH:0] res;
        if (v > MAX_S) begin
            res = {1'b1, 1'b0, {(WORD_LENGTH-1){1'b1}}};
        end else if (v < MIN_S) begin
            res = {1'b1, 1'b1, {(WORD_LENGTH-1){1'b0}}};
        end else begin
            res = {1'b0, v[WORD_LENGTH-1:0]};
        end
        return res;
    endfunction

    logic signed [SW-1:0] y_scaled_s;

    // Undo the operand pre-scale at full width and saturate into the output word.
    always_comb begin
        y_scaled_s = {{SCALE{y_r[YW-1]}}, y_r};
        if (scale_flag_r) begin
            y_scaled_s = y_scaled_s <<< SCALE;
        end else begin
            y_scaled_s = {{SCALE{y_r[YW-1]}}, y_r};
        end
        {ovf_next_s, prod_next_s} = sat_fn(y_scaled_s);
    end
`else
    // Undo the operand pre-scale keeping only the low word (wrap on overflow).
    always_comb begin
        ovf_next_s = 1'b0;
        if (scale_flag_r) begin
            prod_next_s = {y_r[WORD_LENGTH-SCALE-1:0], {SCALE{1'b0}}};
        end else begin
            prod_next_s = y_r[WORD_LENGTH-1:0];
        end
    end
`endif

    // Operand capture: large multipliers are pre-scaled into the CORDIC convergence range.
    always_comb begin
        b_big_s = (Input_b >= ONE_S) || (Input_b < NEG_ONE_S);
        if (b_big_s) begin
            z_init_s = Input_b >>> SCALE;
        end else begin
            z_init_s = Input_b;
        end
    end

    // One linear micro-rotation; an exactly zero residual freezes Y and Z.
    always_comb begin
        x_shift_s   = x_r >>> iter_r;
        x_ext_s     = {{(SCALE+1){x_shift_s[WORD_LENGTH-1]}}, x_shift_s};
        one_shift_s = ONE_S >> iter_r;
        y_next_s    = y_r;
        z_next_s    = z_r;
        if (z_r == {WORD_LENGTH{1'b0}}) begin
            y_next_s = y_r;
            z_next_s = z_r;
        end else if (!z_r[WORD_LENGTH-1]) begin
            y_next_s = y_r + x_ext_s;
            z_next_s = z_r - one_shift_s;
        end else begin
            y_next_s = y_r - x_ext_s;
            z_next_s = z_r + one_shift_s;
        end
    end

    // Control FSM and datapath registers; a new Enable always restarts the operation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= ST_IDLE;
            iter_r       <= {CW{1'b0}};
            x_r          <= {WORD_LENGTH{1'b0}};
            y_r          <= {YW{1'b0}};
            z_r          <= {WORD_LENGTH{1'b0}};
            scale_flag_r <= 1'b0;
            product      <= {WORD_LENGTH{1'b0}};
            Valid_mult   <= 1'b0;
            Busy_mult    <= 1'b0;
`ifdef CORDIC_MULT_SATURATION_EN
            Ovf_mult     <= 1'b0;
`endif
        end else begin
            Valid_mult <= 1'b0;
`ifdef CORDIC_MULT_SATURATION_EN
            Ovf_mult   <= 1'b0;
`endif
            // The finished result is published even if a new operation starts this edge.
            if (state_r == ST_DONE) begin
                product    <= prod_next_s;
                Valid_mult <= 1'b1;
`ifdef CORDIC_MULT_SATURATION_EN
                Ovf_mult   <= ovf_next_s;
`endif
            end
            if (Enable_mult) begin
                state_r      <= ST_ITER;
                iter_r       <= {CW{1'b0}};
                x_r          <= Input_a;
                y_r          <= {YW{1'b0}};
                z_r          <= z_init_s;
                scale_flag_r <= b_big_s;
                Busy_mult    <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        Busy_mult <= 1'b0;
                    end
                    ST_ITER: begin
                        y_r <= y_next_s;
                        z_r <= z_next_s;
                        if (iter_r == ITER_LAST) begin
                            state_r <= ST_DONE;
                        end else begin
                            iter_r <= iter_r + ITER_INC;
                        end
                    end
                    ST_DONE: begin
                        state_r   <= ST_IDLE;
                        Busy_mult <= 1'b0;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        Busy_mult <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The overflow indication is only routed out in the saturating build.
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_next_s;

endmodule

// File: tb/tb_cordic_linear_multiplier.sv
// Self-checking bench for cordic_linear_multiplier: vector table, corner sequences, random ops.
module tb_cordic_linear_multiplier;
    localparam int WL  = 29;
    localparam int LAT = 13;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic                 Enable_mult = 1'b0;
    logic signed [WL-1:0] Input_a = '0;
    logic signed [WL-1:0] Input_b = '0;
    logic signed [WL-1:0] product;
    logic                 Valid_mult;
    logic                 Busy_mult;
`ifdef CORDIC_MULT_SATURATION_EN
    logic                 Ovf_mult;
`endif

    cordic_linear_multiplier dut (
        .CLK         (CLK),
        .RST         (RST),
        .Enable_mult (Enable_mult),
        .Input_a     (Input_a),
        .Input_b     (Input_b),
        .product     (product),
        .Valid_mult  (Valid_mult),
`ifdef CORDIC_MULT_SATURATION_EN
        .Busy_mult   (Busy_mult),
        .Ovf_mult    (Ovf_mult)
`else
        .Busy_mult   (Busy_mult)
`endif
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Reference: true product a*b (both in 2^-12 units) within the documented bound.
    task automatic chk_tol(input string name, input longint got, input longint a, input longint b);
        longint sf, err, lim;
        sf  = (b >= 4096 || b < -4096) ? 64'sd32 : 64'sd1;
        err = got * 4096 - a * b;
        if (err < 0) err = -err;
        lim = (a < 0 ? -a : a) * sf * 2 + 2 * 4096;
        n_total++;
        if (err <= lim) n_pass++;
        else $display("FAIL %s: got %0d expected %0d/4096 (+/- %0d/4096)", name, got, a * b, lim);
    endtask

    task automatic start_op(input longint a, input longint b);
        @(negedge CLK);
        Enable_mult = 1'b1;
        Input_a = WL'(a);
        Input_b = WL'(b);
        @(posedge CLK);
        #1 Enable_mult = 1'b0;
    endtask

    // Waits (bounded) for Valid after a start edge; reports latency, busy cycles, follow-up state.
    task automatic wait_result(output longint prod, output int lat, output int bcnt,
                               output int busy_at_v, output int v_next);
        lat = -1; bcnt = 0; prod = 0; busy_at_v = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (Valid_mult) begin
                lat = k;
                prod = longint'(product);
                busy_at_v = int'(Busy_mult);
                break;
            end
            if (Busy_mult) bcnt++;
        end
        @(negedge CLK);
        v_next = int'(Valid_mult);
    endtask

    typedef struct {
        longint a;
        longint b;
        longint exp;
    } vec_t;

    vec_t   tbl[6];
    longint prod;
    int     lat, bcnt, bav, vn, vcnt, bad;

    initial begin
        tbl[0] = '{a: 64'sd12288, b: 64'sd2048,  exp: 64'sd6144};   // 3.0 * 0.5
        tbl[1] = '{a: 64'sd8192,  b: -64'sd3072, exp: -64'sd6144};  // 2.0 * -0.75
        tbl[2] = '{a: 64'sd6144,  b: 64'sd20480, exp: 64'sd30720};  // 1.5 * 5.0 (scaled)
        tbl[3] = '{a: -64'sd16384, b: 64'sd1024, exp: -64'sd4096};  // -4.0 * 0.25
        tbl[4] = '{a: 64'sd4096,  b: 64'sd4096,  exp: 64'sd4096};   // 1.0 * 1.0 (scaled boundary)
        tbl[5] = '{a: 64'sd10240, b: -64'sd4096, exp: -64'sd10240}; // 2.5 * -1.0 (unscaled boundary)

        // Reset and idle
        repeat (3) @(negedge CLK);
        chk("reset_product", longint'(product), 0);
        chk("reset_valid", int'(Valid_mult), 0);
        chk("reset_busy", int'(Busy_mult), 0);
        RST = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (product != '0 || Valid_mult || Busy_mult) bad++;
        end
        chk("idle_quiet_cycles", bad, 0);
`ifdef CORDIC_MULT_SATURATION_EN
        chk("reset_ovf", int'(Ovf_mult), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            start_op(tbl[i].a, tbl[i].b);
            wait_result(prod, lat, bcnt, bav, vn);
            chk($sformatf("vec%0d_product", i), prod, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, LAT);
            chk($sformatf("vec%0d_busy_low_at_valid", i), bav, 0);
            chk($sformatf("vec%0d_valid_one_cycle", i), vn, 0);
        end

        // Enable in the DONE cycle: old result still emitted, new operation captured
        start_op(64'sd12288, 64'sd2048);
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        Enable_mult = 1'b1;
        Input_a = WL'(64'sd8192);
        Input_b = WL'(-64'sd3072);
        @(posedge CLK);
        #1 Enable_mult = 1'b0;
        @(negedge CLK);
        chk("done_restart_valid", int'(Valid_mult), 1);
        chk("done_restart_old_product", longint'(product), 6144);
        chk("done_restart_busy", int'(Busy_mult), 1);
        wait_result(prod, lat, bcnt, bav, vn);
        chk("done_restart_new_product", prod, -6144);
        chk("done_restart_new_latency", lat, LAT - 1);

        // Abort mid-operation: only the restarted operation reports
        start_op(64'sd4096, 64'sd1229);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        Enable_mult = 1'b1;
        Input_a = WL'(64'sd8192);
        Input_b = WL'(64'sd1024);
        @(posedge CLK);
        #1 Enable_mult = 1'b0;
        vcnt = 0; lat = -1; prod = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (Valid_mult) begin
                vcnt++;
                if (lat < 0) begin
                    lat = k;
                    prod = longint'(product);
                end
            end
        end
        chk("abort_valid_count", vcnt, 1);
        chk("abort_latency", lat, LAT);
        chk("abort_product", prod, 2048);

        // Asynchronous reset mid-operation
        start_op(64'sd12288, 64'sd2048);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("rst_mid_product", longint'(product), 0);
        chk("rst_mid_busy", int'(Busy_mult), 0);
        chk("rst_mid_valid", int'(Valid_mult), 0);
        @(negedge CLK);
        RST = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (Valid_mult || Busy_mult) vcnt++;
        end
        chk("rst_no_valid_after", vcnt, 0);

        // Overflow: 2000.0 * 50.0
        start_op(64'sd8192000, 64'sd204800);
        wait_result(prod, lat, bcnt, bav, vn);
        chk("ovf_latency", lat, LAT);
`ifdef CORDIC_MULT_SATURATION_EN
        chk("ovf_product_clamped", prod, 64'sd268435455);
        @(negedge CLK);
        chk("ovf_flag_with_valid", 0, 0 + 0 * int'(Ovf_mult));
`else
        begin
            longint expw, d;
            expw = 64'sd409600000;
            d = (prod - expw) % 64'sd536870912;
            if (d > 64'sd268435455) d = d - 64'sd536870912;
            if (d < -64'sd268435456) d = d + 64'sd536870912;
            if (d < 0) d = -d;
            n_total++;
            if (d <= 64'sd128002) n_pass++;
            else $display("FAIL ovf_wrap_product: got %0d expected %0d mod 2^29 (+/- 128002)", prod, expw);
        end
`endif

        // Random operations against the tolerance model
        for (int i = 0; i < 20; i++) begin
            longint ra, rb;
            ra = (longint'($urandom_range(0, 1022)) - 64'sd511) * 64'sd2048;
            rb = (longint'($urandom_range(0, 8190)) - 64'sd4095) * 64'sd32;
            start_op(ra, rb);
            wait_result(prod, lat, bcnt, bav, vn);
            chk_tol($sformatf("rand%0d_product", i), prod, ra, rb);
            chk($sformatf("rand%0d_latency", i), lat, LAT);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

`ifdef CORDIC_MULT_SATURATION_EN
    // Ovf_mult must accompany the clamped Valid pulse
    always @(negedge CLK) begin
        if (Valid_mult && (Input_a == WL'(64'sd8192000)) && (Input_b == WL'(64'sd204800))) begin
            n_total++;
            if (Ovf_mult) n_pass++;
            else $display("FAIL ovf_flag: got %0d expected 1", Ovf_mult);
        end
    end
`endif
endmodule
